// File: rtl/johnson_decoder.sv
// johnson_decoder
//   Decodes sampled 8-bit Johnson (twisted-ring) code words into a 0..15
//   position, flags illegal words and out-of-order steps, and tracks lock to
//   a continuously advancing sequence.
//
// Parameters
//   LOCK_CNT   consecutive correct steps needed to reach LOCKED (1..15)
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   code_in    sampled Johnson code word
//   code_vld   code_in is valid this cycle
//   clr_err    synchronous clear of err_cnt (wins over a same-cycle error)
//   idx        last decoded legal position
//   idx_vld    one-cycle pulse, idx updated from a legal code
//   illegal    one-cycle pulse, sampled word is not a Johnson code
//   seq_err    one-cycle pulse, legal code but wrong step while LOCKED
//   locked     decoder is in LOCKED
//   err_cnt    saturating count of illegal + seq_err events
//
// Build option
//   JDEC_ERRCNT_EN  when defined, err_cnt/clr_err are implemented; otherwise
//                   err_cnt is tied to 0 and clr_err is ignored.
//
// State  | meaning
// NOREF  | no reference position held (after reset or an illegal word)
// UNLOCKED | reference held, counting consecutive correct steps in run
// LOCKED | LOCK_CNT consecutive correct steps seen

module johnson_decoder #(
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code_in,
  input  logic       code_vld,
  input  logic       clr_err,
  output logic [3:0] idx,
  output logic       idx_vld,
  output logic       illegal,
  output logic       seq_err,
  output logic       locked,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] LOCK_CNT_W = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_NOREF    = 2'd0,
    S_UNLOCKED = 2'd1,
    S_LOCKED   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] run_q, run_d;
  logic [3:0] idx_q, idx_d;
  logic       idx_vld_q, idx_vld_d;
  logic       illegal_q, illegal_d;
  logic       seq_err_q, seq_err_d;

  logic [3:0] dec_idx;
  logic       dec_legal;
  logic [3:0] idx_inc;
  logic [3:0] run_inc;
  logic       step_ok;

  always_comb begin
    dec_idx   = 4'd0;
    dec_legal = 1'b1;
    case (code_in)
      8'h00: dec_idx = 4'd0;
      8'h80: dec_idx = 4'd1;
      8'hC0: dec_idx = 4'd2;
      8'hE0: dec_idx = 4'd3;
      8'hF0: dec_idx = 4'd4;
      8'hF8: dec_idx = 4'd5;
      8'hFC: dec_idx = 4'd6;
      8'hFE: dec_idx = 4'd7;
      8'hFF: dec_idx = 4'd8;
      8'h7F: dec_idx = 4'd9;
      8'h3F: dec_idx = 4'd10;
      8'h1F: dec_idx = 4'd11;
      8'h0F: dec_idx = 4'd12;
      8'h07: dec_idx = 4'd13;
      8'h03: dec_idx = 4'd14;
      8'h01: dec_idx = 4'd15;
      default: dec_legal = 1'b0;
    endcase
  end

  // idx_q always holds the last legal position, so it doubles as the
  // reference; 4-bit wrap makes 15 -> 0 a correct step.
  assign idx_inc = idx_q + 4'd1;
  assign run_inc = run_q + 4'd1;
  assign step_ok = (dec_idx == idx_inc);

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    idx_d     = idx_q;
    idx_vld_d = 1'b0;
    illegal_d = 1'b0;
    seq_err_d = 1'b0;

    if (code_vld) begin
      if (!dec_legal) begin
        illegal_d = 1'b1;
        state_d   = S_NOREF;
        run_d     = 4'd0;
      end else begin
        idx_vld_d = 1'b1;
        idx_d     = dec_idx;
        case (state_q)
          S_NOREF: begin
            state_d = S_UNLOCKED;
            run_d   = 4'd0;
          end
          S_UNLOCKED: begin
            if (step_ok) begin
              run_d = run_inc;
              if (run_inc >= LOCK_CNT_W) begin
                state_d = S_LOCKED;
              end
            end else begin
              run_d = 4'd0;
            end
          end
          S_LOCKED: begin
            if (!step_ok) begin
              seq_err_d = 1'b1;
              state_d   = S_UNLOCKED;
              run_d     = 4'd0;
            end
          end
          default: begin
            state_d = S_NOREF;
            run_d   = 4'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_NOREF;
      run_q     <= 4'd0;
      idx_q     <= 4'd0;
      idx_vld_q <= 1'b0;
      illegal_q <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      idx_q     <= idx_d;
      idx_vld_q <= idx_vld_d;
      illegal_q <= illegal_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign idx     = idx_q;
  assign idx_vld = idx_vld_q;
  assign illegal = illegal_q;
  assign seq_err = seq_err_q;
  assign locked  = (state_q == S_LOCKED);

`ifdef JDEC_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = 8'd0;
    end else if ((illegal_d || seq_err_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign err_cnt        = 8'd0;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
module tb_johnson_decoder;

  localparam int LOCK_CNT = 4;
`ifdef JDEC_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] code_in;
  logic       code_vld;
  logic       clr_err;
  logic [3:0] idx;
  logic       idx_vld;
  logic       illegal;
  logic       seq_err;
  logic       locked;
  logic [7:0] err_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  bit m_have_ref;
  int m_ref;
  int m_run;
  bit m_locked;
  int m_err;
  int m_idx;
  bit m_vld, m_ill, m_seq;

  johnson_decoder #(.LOCK_CNT(LOCK_CNT)) dut (
    .clk     (clk),
    .rst     (rst),
    .code_in (code_in),
    .code_vld(code_vld),
    .clr_err (clr_err),
    .idx     (idx),
    .idx_vld (idx_vld),
    .illegal (illegal),
    .seq_err (seq_err),
    .locked  (locked),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Johnson word for position i, from the ones-packing rule.
  function automatic logic [7:0] jcode(input int i);
    int v;
    if (i <= 8) v = ((1 << i) - 1) << (8 - i);
    else        v = (1 << (16 - i)) - 1;
    return 8'(v);
  endfunction

  function automatic int jlookup(input logic [7:0] c);
    for (int i = 0; i < 16; i++) begin
      if (jcode(i) == c) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_have_ref = 0; m_ref = 0; m_run = 0; m_locked = 0;
    m_err = 0; m_idx = 0; m_vld = 0; m_ill = 0; m_seq = 0;
  endtask

  task automatic model_step(input logic [7:0] c, input logic v, input logic clr);
    int p;
    m_vld = 0; m_ill = 0; m_seq = 0;
    if (v) begin
      p = jlookup(c);
      if (p < 0) begin
        m_ill = 1;
        m_have_ref = 0;
        m_run = 0;
        m_locked = 0;
      end else begin
        m_vld = 1;
        m_idx = p;
        if (!m_have_ref) begin
          m_run = 0;
          m_locked = 0;
        end else if (p == (m_ref + 1) % 16) begin
          if (!m_locked) begin
            m_run++;
            if (m_run >= LOCK_CNT) m_locked = 1;
          end
        end else begin
          if (m_locked) m_seq = 1;
          m_locked = 0;
          m_run = 0;
        end
        m_have_ref = 1;
        m_ref = p;
      end
    end
    if (ERR_EN) begin
      if (clr) m_err = 0;
      else if ((m_ill || m_seq) && m_err < 255) m_err++;
    end else begin
      m_err = 0;
    end
  endtask

  task automatic compare_all();
    check("idx", int'(idx), m_idx);
    check("idx_vld", int'(idx_vld), int'(m_vld));
    check("illegal", int'(illegal), int'(m_ill));
    check("seq_err", int'(seq_err), int'(m_seq));
    check("locked", int'(locked), int'(m_locked));
    check("err_cnt", int'(err_cnt), m_err);
  endtask

  task automatic step(input logic [7:0] c, input logic v, input logic clr);
    @(negedge clk);
    code_in = c; code_vld = v; clr_err = clr;
    @(posedge clk);
    model_step(c, v, clr);
    #1;
    compare_all();
  endtask

  // Asserts rst between edges with a sample pending and checks the outputs
  // clear without a clock edge.
  task automatic async_reset();
    @(negedge clk);
    code_in = jcode(3); code_vld = 1'b1; clr_err = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_idx", int'(idx), 0);
    check("rst_idx_vld", int'(idx_vld), 0);
    check("rst_illegal", int'(illegal), 0);
    check("rst_seq_err", int'(seq_err), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    model_reset();
    @(negedge clk);
    code_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; code_in = 8'h00; code_vld = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("init_idx", int'(idx), 0);
    check("init_locked", int'(locked), 0);
    check("init_err_cnt", int'(err_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // full sequence 0..15,0; lock on the fifth sample
    for (int i = 0; i <= 16; i++) begin
      step(jcode(i % 16), 1'b1, 1'b0);
      if (i == 3) check("lock_early", int'(locked), 0);
      if (i == 4) check("lock_rise", int'(locked), 1);
    end

    // relock and stop at idx 8, then skip to 10
    async_reset();
    for (int i = 0; i <= 8; i++) step(jcode(i), 1'b1, 1'b0);
    step(8'h3F, 1'b1, 1'b0);
    check("skip_seq_err", int'(seq_err), 1);
    step(8'h1F, 1'b1, 1'b0);
    check("after_skip_idx", int'(idx), 11);
    step(8'h0F, 1'b1, 1'b0);
    step(8'h07, 1'b1, 1'b0);
    step(8'h03, 1'b1, 1'b0);
    step(8'hA5, 1'b1, 1'b0);
    check("a5_illegal", int'(illegal), 1);
    step(8'h01, 1'b1, 1'b0);
    check("after_ill_seq", int'(seq_err), 0);

    // saturation and clear-wins
    for (int i = 0; i < 300; i++) step(8'hA5, 1'b1, 1'b0);
    step(8'h5A, 1'b1, 1'b1);
    check("clr_wins", int'(err_cnt), 0);
    step(8'h5A, 1'b1, 1'b0);

    // gapped valid
    async_reset();
    step(8'h80, 1'b1, 1'b0);
    step(8'h11, 1'b0, 1'b0);
    step(8'h22, 1'b0, 1'b0);
    step(8'hC0, 1'b1, 1'b0);
    step(8'hE0, 1'b1, 1'b0);
    async_reset();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] c;
      logic v, clr;
      int p;
      v   = ($urandom_range(0, 99) < 80);
      clr = ($urandom_range(0, 59) == 0);
      p   = $urandom_range(0, 99);
      if (p < 70)      c = jcode((m_ref + 1) % 16);
      else if (p < 85) c = jcode($urandom_range(0, 15));
      else             c = 8'($urandom);
      if ($urandom_range(0, 399) == 0) async_reset();
      else step(c, v, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter LOCK_CNT, default 4, meaning consecutive correct steps required to reach LOCKED (range 1..15).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 code_in  input  8  sampled 8-bit Johnson (twisted-ring) code word.
REQ-005 code_vld  input  1  code_in is sampled on this cycle.
REQ-006 clr_err  input  1  synchronous clear of err_cnt.
REQ-007 idx  output  4  decoded position 0..15.
REQ-008 idx_vld  output  1  one-cycle pulse: idx updated from a legal code.
REQ-009 illegal  output  1  one-cycle pulse: sampled code not in the 16-code set.
REQ-010 seq_err  output  1  one-cycle pulse: legal code, wrong step, while LOCKED.
REQ-011 locked  output  1  FSM is in LOCKED.
REQ-012 err_cnt  output  8  saturating count of illegal plus seq_err events.

Function
REQ-013 The legal code set SHALL be: 0x00; k ones packed from bit 7 downward (k=1..8) -> idx=k; k ones packed from bit 0 upward (k=1..7, bit 7 = 0) -> idx=16-k.
REQ-014 Any other code_in value SHALL be illegal.
REQ-015 All outputs SHALL be registered; the response to a sample SHALL appear exactly 1 cycle after the cycle with code_vld=1.
REQ-016 With code_vld=0, idx SHALL hold, and idx_vld, illegal and seq_err SHALL be 0.
REQ-017 On a legal sample: idx_vld=1 and idx=decoded value; on an illegal sample: illegal=1, idx_vld=0, idx held.
REQ-018 Correct step SHALL mean new idx == (previous legal idx + 1) mod 16; 15 -> 0 SHALL be correct.
REQ-019 A repeated idx SHALL be a wrong step.
REQ-020 FSM states: NOREF (no reference), UNLOCKED, LOCKED.
REQ-021 NOREF + legal -> UNLOCKED with run=0; NOREF + illegal -> NOREF.
REQ-022 UNLOCKED + correct step -> run+1; entry to LOCKED when run reaches LOCK_CNT.
REQ-023 UNLOCKED + wrong step -> run=0 and the sample becomes the new reference; seq_err=0.
REQ-024 LOCKED + correct step -> stays LOCKED.
REQ-025 LOCKED + wrong step -> seq_err=1, UNLOCKED, run=0, and the sample becomes the reference.
REQ-026 Any state + illegal -> NOREF, run=0.
REQ-027 locked SHALL be asserted in the same cycle as the idx_vld of the sample that completes the run.
REQ-028 err_cnt SHALL increment by 1 per illegal or seq_err pulse and saturate at 255.
REQ-029 If clr_err and an error event occur in the same cycle, clear SHALL win and err_cnt SHALL become 0.

Reset
REQ-030 rst=1 SHALL immediately force: state NOREF, run=0, idx=0, idx_vld=0, illegal=0, seq_err=0, locked=0, err_cnt=0.
REQ-031 A sample in flight when rst asserts SHALL be discarded; the first sample after release SHALL be treated as from NOREF.

Configuration
REQ-032 Macro JDEC_ERRCNT_EN defined: err_cnt and clr_err behave per REQ-028/029.
REQ-033 Macro JDEC_ERRCNT_EN undefined: no counter logic; err_cnt is tied to 0; clr_err is ignored; all other behaviour is unchanged.

Verification
REQ-034 Reset, then feed the 16-code Johnson sequence from 0x00 with code_vld=1 every cycle -> idx 0,1,...,15,0; locked rises on the 5th sample (LOCK_CNT=4); no errors.
REQ-035 Once LOCKED at idx=8 (0xFF), send 0x3F (idx 10) -> seq_err=1, locked=0, err_cnt=1; then 0x1F (idx 11) continues from reference 10 in UNLOCKED.
REQ-036 Send 0xA5 while LOCKED -> illegal=1, idx_vld=0, idx held, NOREF, err_cnt+1; the next legal code produces no seq_err.
REQ-037 Force 300 illegal samples (JDEC_ERRCNT_EN defined) -> err_cnt stops at 255; clr_err with a simultaneous illegal sample -> err_cnt=0.
REQ-038 Gapped code_vld (1,0,0,1) over codes 0x80, 0xC0 -> counts as a correct step; assert rst mid-run -> all outputs 0 asynchronously, locked=0.
